// File: rtl/rf_pkg.sv
// Shared types and constants for the register-fetch stage.
// No logic; sizes the register file, scoreboard counters and issue bundle.
// Not applicable: no handshakes live in this package.
package rf_pkg;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;
    localparam int MAX_PEND  = 5;
    localparam int PEND_W    = 3;
    localparam int PASS_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [PEND_W-1:0]    pend_cnt_t;

    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        reg_idx_t          rd;
        logic              wr_rd;
        logic [PASS_W-1:0] payload;
    } issue_bundle_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with issue increment and writeback decrement.
// Latency: busy counts read combinationally, updates visible the cycle after the edge.
// Backpressure: none; the caller stalls issue so counters never exceed MAX_PEND.
module reg_scoreboard
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      inc_vld,
    input  reg_idx_t  inc_idx,
    input  logic      dec_vld,
    input  reg_idx_t  dec_idx,
    input  reg_idx_t  rs1_idx,
    input  reg_idx_t  rs2_idx,
    input  reg_idx_t  rd_idx,
    output pend_cnt_t rs1_busy,
    output pend_cnt_t rs2_busy,
    output pend_cnt_t rd_busy,
    output logic      sb_err
);
    pend_cnt_t cnt     [NREGS];
    pend_cnt_t cnt_nxt [NREGS];
    logic      err_nxt;

    always_comb begin
        err_nxt = sb_err;
        for (int i = 0; i < NREGS; i++) begin
            logic inc;
            logic dec;
            cnt_nxt[i] = cnt[i];
            inc = inc_vld && (inc_idx == reg_idx_t'(i)) && (i != 0);
            dec = dec_vld && (dec_idx == reg_idx_t'(i)) && (i != 0);
            // A writeback with nothing outstanding is still an error even if an
            // issue to the same register lands in the same cycle.
            if (dec && cnt[i] == '0)
                err_nxt = 1'b1;
            if (inc && !dec) begin
                if (cnt[i] == pend_cnt_t'(MAX_PEND))
                    err_nxt = 1'b1;
                else
                    cnt_nxt[i] = cnt[i] + pend_cnt_t'(1);
            end else if (dec && !inc) begin
                if (cnt[i] != '0)
                    cnt_nxt[i] = cnt[i] - pend_cnt_t'(1);
            end else if (inc && dec && cnt[i] == '0) begin
                cnt_nxt[i] = pend_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                cnt[i] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                cnt[i] <= cnt_nxt[i];
            sb_err <= err_nxt;
        end
    end

    assign rs1_busy = cnt[rs1_idx];
    assign rs2_busy = cnt[rs2_idx];
    assign rd_busy  = cnt[rd_idx];
endmodule

// File: rtl/reg_fetch_stage.sv
// Register fetch: hazard check, operand read with writeback bypass, one-deep output register.
// Latency: 1 cycle from issue (id_valid && id_ready) to ex_valid.
// Backpressure: id_ready drops on RAW/pending-limit hazards or when the held bundle is not consumed.
module reg_fetch_stage
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_wr_rd,
    input  logic [PASS_W-1:0] id_payload,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [4:0]        ex_rd,
    output logic              ex_wr_rd,
    output logic [PASS_W-1:0] ex_payload,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              sb_err
);
    logic [XLEN-1:0] rf [NREGS];
    issue_bundle_t   bundle;
    pend_cnt_t       rs1_busy, rs2_busy, rd_busy;
    logic            wr_eff, wb_eff, byp1, byp2, hazard, out_free, issue;
    logic [XLEN-1:0] op1_val, op2_val;

    reg_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_vld  (issue && wr_eff),
        .inc_idx  (id_rd),
        .dec_vld  (wb_eff),
        .dec_idx  (wb_rd),
        .rs1_idx  (id_rs1),
        .rs2_idx  (id_rs2),
        .rd_idx   (id_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .sb_err   (sb_err)
    );

    assign wr_eff = id_wr_rd && (id_rd != '0);
    assign wb_eff = wb_valid && (wb_rd != '0);

    // Bypass only the last outstanding write; an older in-flight write would be stale.
    assign byp1 = wb_valid && (wb_rd == id_rs1) && (rs1_busy == pend_cnt_t'(1));
    assign byp2 = wb_valid && (wb_rd == id_rs2) && (rs2_busy == pend_cnt_t'(1));

    assign hazard = (id_use_rs1 && (rs1_busy != '0) && !byp1) ||
                    (id_use_rs2 && (rs2_busy != '0) && !byp2) ||
                    (wr_eff && (rd_busy == pend_cnt_t'(MAX_PEND)));

    assign out_free = !ex_valid || ex_ready;
    assign id_ready = out_free && !hazard;
    assign issue    = id_valid && id_ready;

    always_comb begin
        op1_val = '0;
        op2_val = '0;
        if (id_use_rs1)
            op1_val = byp1 ? wb_data : ((id_rs1 == '0) ? '0 : rf[id_rs1]);
        if (id_use_rs2)
            op2_val = byp2 ? wb_data : ((id_rs2 == '0) ? '0 : rf[id_rs2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_eff) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            bundle   <= '0;
        end else if (issue) begin
            ex_valid <= 1'b1;
            bundle   <= '{op1: op1_val, op2: op2_val, rd: id_rd, wr_rd: wr_eff, payload: id_payload};
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_op1     = bundle.op1;
    assign ex_op2     = bundle.op2;
    assign ex_rd      = bundle.rd;
    assign ex_wr_rd   = bundle.wr_rd;
    assign ex_payload = bundle.payload;
endmodule
